gray_counter_n: RTL and testbench

- Parametrised up/down Gray-code counter with synchronous load, sticky overflow/underflow flags and a one-cycle wrap strobe.
- Next-generation replacement for the fixed 3-bit up-only Gray counter.
- Used as a pointer/sequence source in datapath and FIFO-style blocks, where only one output bit may change per step.
- Drives registered Gray and binary views of the same count.

---
 rtl/gray_counter_n.sv | 114 +++++++++++
 tb/tb_gray_counter_n.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised up/down Gray-code counter.
// A single binary register holds the count; the Gray view is derived from
// the next binary value and registered beside it, so both views update on
// the same edge and no input reaches an output combinationally.
// Load takes a Gray-encoded value. Overflow/Underflow are sticky wrap flags,
// and Wrap is a one-cycle strobe that accompanies the wrapped value.
// Build option: define GRAY_COUNTER_SAT_EN for saturating mode. In that mode
// a step that would wrap holds at max/0 instead, still sets the matching
// flag, and Wrap is never asserted.
module gray_counter_n #(
  parameter int WIDTH    = 3,
  parameter int INIT_BIN = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadGray,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] INIT_B  = WIDTH'(INIT_BIN);
  localparam logic [WIDTH-1:0] INIT_G  = INIT_B ^ (INIT_B >> 1);
  localparam logic [WIDTH-1:0] MAX_B   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_B  = '0;
  localparam logic [WIDTH-1:0] ONE_B   = WIDTH'(1);

  // Power-up values match the reset values.
  logic [WIDTH-1:0] b_reg    = INIT_B;
  logic [WIDTH-1:0] gray_reg = INIT_G;
  logic             ovf_reg  = 1'b0;
  logic             unf_reg  = 1'b0;
  logic             wrap_reg = 1'b0;

  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] gray_next;
  logic             ovf_next;
  logic             unf_next;
  logic             wrap_next;
  logic [WIDTH-1:0] load_bin;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above
  // it. Written per bit so there is no ripple chain through one vector.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
    assign load_bin[gi] = ^LoadGray[WIDTH-1:gi];
  end

  // Next-state selection: load beats counting; flags clear first so a wrap
  // in the same cycle as FlagClr re-sets its own flag.
  always_comb begin
    b_next    = b_reg;
    wrap_next = 1'b0;
    ovf_next  = ovf_reg & ~FlagClr;
    unf_next  = unf_reg & ~FlagClr;
    if (Load) begin
      b_next = load_bin;
    end else if (En && Dir) begin
      if (b_reg == MAX_B) begin
        ovf_next = 1'b1;
`ifdef GRAY_COUNTER_SAT_EN
        b_next = MAX_B;
`else
        b_next    = ZERO_B;
        wrap_next = 1'b1;
`endif
      end else begin
        b_next = b_reg + ONE_B;
      end
    end else if (En) begin
      if (b_reg == ZERO_B) begin
        unf_next = 1'b1;
`ifdef GRAY_COUNTER_SAT_EN
        b_next = ZERO_B;
`else
        b_next    = MAX_B;
        wrap_next = 1'b1;
`endif
      end else begin
        b_next = b_reg - ONE_B;
      end
    end
    gray_next = b_next ^ (b_next >> 1);
  end

  // State and output registers; Reset dominates everything else.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      b_reg    <= INIT_B;
      gray_reg <= INIT_G;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      b_reg    <= b_next;
      gray_reg <= gray_next;
      ovf_reg  <= ovf_next;
      unf_reg  <= unf_next;
      wrap_reg <= wrap_next;
    end
  end

  assign Output    = gray_reg;
  assign BinOut    = b_reg;
  assign Overflow  = ovf_reg;
  assign Underflow = unf_reg;
  assign Wrap      = wrap_reg;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n (WIDTH=3, INIT_BIN=5).
// The driver applies one input set per cycle on the falling edge and pushes
// the expected post-edge state from an integer model; the monitor pops one
// entry after every rising edge and compares all outputs.
module tb_gray_counter_n;

  localparam int W    = 3;
  localparam int INIT = 5;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int bin;
    int ovf;
    int unf;
    int wrap;
    bit step;   // the count moved by one, so exactly one Gray bit must flip
  } exp_t;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         En = 1'b0;
  logic         Dir = 1'b0;
  logic         Load = 1'b0;
  logic [W-1:0] LoadGray = '0;
  logic         FlagClr = 1'b0;
  logic [W-1:0] Output;
  logic [W-1:0] BinOut;
  logic         Overflow;
  logic         Underflow;
  logic         Wrap;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int m_cnt  = INIT;
  int m_ovf  = 0;
  int m_unf  = 0;
  int m_wrap = 0;

  gray_counter_n #(.WIDTH(W), .INIT_BIN(INIT)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadGray(LoadGray), .FlagClr(FlagClr), .Output(Output),
    .BinOut(BinOut), .Overflow(Overflow), .Underflow(Underflow), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  function automatic int gray_of(int v);
    return v ^ (v >> 1);
  endfunction

  // Decode by searching for the count whose Gray code matches.
  function automatic int bin_of_gray(int g);
    for (int v = 0; v <= MAXV; v++)
      if (gray_of(v) == g) return v;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit en, input bit dir, input bit ld,
                       input int lg, input bit fc);
    exp_t e;
    int   prev;
    @(negedge Clk);
    Reset = r; En = en; Dir = dir; Load = ld; LoadGray = W'(lg); FlagClr = fc;
    prev = m_cnt;
    if (r) begin
      m_cnt = INIT; m_ovf = 0; m_unf = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (fc) begin m_ovf = 0; m_unf = 0; end
      if (ld) begin
        m_cnt = bin_of_gray(lg);
      end else if (en && dir) begin
        if (m_cnt == MAXV) begin
          m_ovf = 1;
`ifndef GRAY_COUNTER_SAT_EN
          m_cnt = 0; m_wrap = 1;
`endif
        end else m_cnt = m_cnt + 1;
      end else if (en) begin
        if (m_cnt == 0) begin
          m_unf = 1;
`ifndef GRAY_COUNTER_SAT_EN
          m_cnt = MAXV; m_wrap = 1;
`endif
        end else m_cnt = m_cnt - 1;
      end
    end
    e.bin = m_cnt; e.ovf = m_ovf; e.unf = m_unf; e.wrap = m_wrap;
    e.step = !r && !ld && en && (m_cnt != prev);
    exp_q.push_back(e);
    $display("txn t=%0t rst=%0b en=%0b dir=%0b ld=%0b lg=%0d fc=%0b -> exp bin=%0d ovf=%0d unf=%0d wrap=%0d",
             $time, r, en, dir, ld, lg, fc, e.bin, e.ovf, e.unf, e.wrap);
  endtask

  // Monitor: power-up state, then one scoreboard entry per rising edge.
  initial begin : monitor
    exp_t       e;
    logic [W-1:0] prev_gray;
    #1;
    check("init_bin", int'(BinOut), INIT);
    check("init_gray", int'(Output), gray_of(INIT));
    check("init_ovf", int'(Overflow), 0);
    check("init_unf", int'(Underflow), 0);
    check("init_wrap", int'(Wrap), 0);
    prev_gray = Output;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bin", int'(BinOut), e.bin);
        check("gray", int'(Output), gray_of(e.bin));
        check("ovf", int'(Overflow), e.ovf);
        check("unf", int'(Underflow), e.unf);
        check("wrap", int'(Wrap), e.wrap);
        if (e.step) check("gray_one_bit", $countones(Output ^ prev_gray), 1);
      end
      prev_gray = Output;
    end
  end

  initial begin : driver
    int wait_cnt;
    // Reset with load/count requests that must be ignored
    drive(1, 1, 1, 1, 3, 1);
    // Load Gray 000 then count up through a full cycle and the wrap
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    // Clear, load max (Gray 100), then load beats count at max
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 4, 0);
    drive(0, 1, 1, 1, 3, 0);
    // Up-wrap sets Overflow; FlagClr without wrap clears it
    drive(0, 0, 0, 1, 4, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    // FlagClr coincident with a fresh up-wrap: set wins
    drive(0, 0, 0, 1, 4, 0);
    drive(0, 1, 1, 0, 0, 1);
    // Down from zero: Underflow; repeated steps at the boundary
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
    // Saturation-style repeat at max going up
    drive(0, 0, 0, 1, 4, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0);
    // Direction flips without a dead cycle
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    // Reset mid-count with En and Load high
    drive(0, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 1, 6, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(49) == 0), ($urandom_range(3) != 0), $urandom_range(1),
            ($urandom_range(7) == 0), $urandom_range(MAXV), ($urandom_range(9) == 0));
    @(negedge Clk);
    Reset = 0; En = 0; Load = 0; FlagClr = 0;
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge Clk);
      wait_cnt++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
